// File: rtl/cache_meta_regfile.sv
// cache_meta_regfile: valid/dirty/LRU metadata storage with a dirty-line flush scan engine.
// The scan walks (idx, way) in order and presents each valid&dirty line until it is accepted.
module cache_meta_regfile #(
  parameter int INDEX_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INDEX_W-1:0] reg_dirty_raddr0,
  input  logic [INDEX_W-1:0] reg_dirty_raddr1,
  output logic               reg_dirty_rdata0,
  output logic               reg_dirty_rdata1,
  input  logic [INDEX_W-1:0] reg_value_raddr0,
  input  logic [INDEX_W-1:0] reg_value_raddr1,
  output logic               reg_value_rdata0,
  output logic               reg_value_rdata1,
  input  logic [INDEX_W-1:0] reg_lru_raddr,
  output logic               reg_lru_rdata,
  input  logic               reg_dirty_wen0,
  input  logic [INDEX_W-1:0] reg_dirty_waddr0,
  input  logic               reg_dirty_wdata0,
  input  logic               reg_dirty_wen1,
  input  logic [INDEX_W-1:0] reg_dirty_waddr1,
  input  logic               reg_dirty_wdata1,
  input  logic               reg_value_wen0,
  input  logic [INDEX_W-1:0] reg_value_waddr0,
  input  logic               reg_value_wdata0,
  input  logic               reg_value_wen1,
  input  logic [INDEX_W-1:0] reg_value_waddr1,
  input  logic               reg_value_wdata1,
  input  logic               reg_lru_wen,
  input  logic [INDEX_W-1:0] reg_lru_waddr,
  input  logic               reg_lru_wdata,
  input  logic               scan_start,
  output logic               scan_busy,
  output logic               scan_valid,
  input  logic               scan_ready,
  output logic [INDEX_W-1:0] scan_idx,
  output logic               scan_way,
  output logic               scan_done
);
  localparam int SETS = 1 << INDEX_W;
  typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;
  state_t            state_q;
  logic [SETS-1:0]   dirty0_q, dirty0_d, dirty1_q, dirty1_d;
  logic [SETS-1:0]   value0_q, value1_q, lru_q;
  logic [INDEX_W-1:0] idx_q;
  logic              way_q;
  logic [INDEX_W:0]  cur_nxt;
  logic              hit, last, clr;
  assign reg_dirty_rdata0 = dirty0_q[reg_dirty_raddr0];
  assign reg_dirty_rdata1 = dirty1_q[reg_dirty_raddr1];
  assign reg_value_rdata0 = value0_q[reg_value_raddr0];
  assign reg_value_rdata1 = value1_q[reg_value_raddr1];
  assign reg_lru_rdata    = lru_q[reg_lru_raddr];
  assign scan_busy  = state_q != IDLE;
  assign scan_valid = state_q == EMIT;
  assign scan_done  = state_q == DONE;
  assign scan_idx   = idx_q;
  assign scan_way   = way_q;
  // {idx, way} as one counter gives way0 -> way1 -> next idx ordering
  assign cur_nxt = {idx_q, way_q} + {{INDEX_W{1'b0}}, 1'b1};
  assign hit  = way_q ? (value1_q[idx_q] & dirty1_q[idx_q]) : (value0_q[idx_q] & dirty0_q[idx_q]);
  assign last = (&idx_q) & way_q;
  assign clr  = (state_q == EMIT) & scan_ready;
  // external dirty writes are applied after the scan clear so they win on collision
  always_comb begin
    dirty0_d = dirty0_q;
    dirty1_d = dirty1_q;
    if (clr && !way_q) dirty0_d[idx_q] = 1'b0;
    if (clr && way_q) dirty1_d[idx_q] = 1'b0;
    if (reg_dirty_wen0) dirty0_d[reg_dirty_waddr0] = reg_dirty_wdata0;
    if (reg_dirty_wen1) dirty1_d[reg_dirty_waddr1] = reg_dirty_wdata1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dirty0_q <= '0;
      dirty1_q <= '0;
      value0_q <= '0;
      value1_q <= '0;
      lru_q    <= '0;
    end else begin
      dirty0_q <= dirty0_d;
      dirty1_q <= dirty1_d;
      if (reg_value_wen0) value0_q[reg_value_waddr0] <= reg_value_wdata0;
      if (reg_value_wen1) value1_q[reg_value_waddr1] <= reg_value_wdata1;
      if (reg_lru_wen) lru_q[reg_lru_waddr] <= reg_lru_wdata;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      way_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (scan_start) begin
          state_q <= SCAN;
          idx_q   <= '0;
          way_q   <= 1'b0;
        end
        SCAN: if (hit) state_q <= EMIT;
        else begin
          {idx_q, way_q} <= cur_nxt;
          state_q <= last ? DONE : SCAN;
        end
        EMIT: if (scan_ready) begin
          {idx_q, way_q} <= cur_nxt;
          state_q <= last ? DONE : SCAN;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_meta_regfile.sv
// tb_cache_meta_regfile: table-driven read/write checks plus directed scan sequences.
module tb_cache_meta_regfile;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] dra0 = '0, dra1 = '0, vra0 = '0, vra1 = '0, lra = '0;
  logic       drd0, drd1, vrd0, vrd1, lrd;
  logic       dwen0 = 0, dwd0 = 0, dwen1 = 0, dwd1 = 0;
  logic       vwen0 = 0, vwd0 = 0, vwen1 = 0, vwd1 = 0, lwen = 0, lwd = 0;
  logic [5:0] dwa0 = '0, dwa1 = '0, vwa0 = '0, vwa1 = '0, lwa = '0;
  logic       scan_start = 0, scan_ready = 0;
  logic       scan_busy, scan_valid, scan_way, scan_done;
  logic [5:0] scan_idx;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  cache_meta_regfile #(.INDEX_W(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .reg_dirty_raddr0(dra0), .reg_dirty_raddr1(dra1),
    .reg_dirty_rdata0(drd0), .reg_dirty_rdata1(drd1),
    .reg_value_raddr0(vra0), .reg_value_raddr1(vra1),
    .reg_value_rdata0(vrd0), .reg_value_rdata1(vrd1),
    .reg_lru_raddr(lra), .reg_lru_rdata(lrd),
    .reg_dirty_wen0(dwen0), .reg_dirty_waddr0(dwa0), .reg_dirty_wdata0(dwd0),
    .reg_dirty_wen1(dwen1), .reg_dirty_waddr1(dwa1), .reg_dirty_wdata1(dwd1),
    .reg_value_wen0(vwen0), .reg_value_waddr0(vwa0), .reg_value_wdata0(vwd0),
    .reg_value_wen1(vwen1), .reg_value_waddr1(vwa1), .reg_value_wdata1(vwd1),
    .reg_lru_wen(lwen), .reg_lru_waddr(lwa), .reg_lru_wdata(lwd),
    .scan_start(scan_start), .scan_busy(scan_busy), .scan_valid(scan_valid),
    .scan_ready(scan_ready), .scan_idx(scan_idx), .scan_way(scan_way), .scan_done(scan_done)
  );

  typedef struct {
    logic [9:0] wctl;
    logic [5:0] wa;
    logic [5:0] ra;
    logic [4:0] exp;
  } vec_t;
  vec_t vec [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ra(input logic [5:0] a);
    dra0 = a; dra1 = a; vra0 = a; vra1 = a; lra = a;
  endtask

  task automatic chk_reads(input string nm, input logic [4:0] exp);
    chk({nm, "_d0"}, {31'd0, drd0}, {31'd0, exp[4]});
    chk({nm, "_d1"}, {31'd0, drd1}, {31'd0, exp[3]});
    chk({nm, "_v0"}, {31'd0, vrd0}, {31'd0, exp[2]});
    chk({nm, "_v1"}, {31'd0, vrd1}, {31'd0, exp[1]});
    chk({nm, "_lru"}, {31'd0, lrd}, {31'd0, exp[0]});
  endtask

  task automatic chk_scan_idle(input string nm);
    chk({nm, "_busy"}, {31'd0, scan_busy}, 0);
    chk({nm, "_valid"}, {31'd0, scan_valid}, 0);
    chk({nm, "_done"}, {31'd0, scan_done}, 0);
    chk({nm, "_idx"}, {26'd0, scan_idx}, 0);
    chk({nm, "_way"}, {31'd0, scan_way}, 0);
  endtask

  initial begin
    int ei [2];
    int ew [2];
    int emits, done_at, seen;
    ei = '{3, 10};
    ew = '{1, 0};
    // wctl = {dw0,dd0,dw1,dd1,vw0,vd0,vw1,vd1,lw,ld}; exp = {d0,d1,v0,v1,lru} read before the edge
    vec[0] = '{10'b11_00_00_00_00, 6'd5,  6'd5,  5'b00000};
    vec[1] = '{10'b00_11_00_00_00, 6'd5,  6'd5,  5'b10000};
    vec[2] = '{10'b00_00_11_11_00, 6'd5,  6'd5,  5'b11000};
    vec[3] = '{10'b10_00_00_00_11, 6'd5,  6'd5,  5'b11110};
    vec[4] = '{10'b00_00_11_00_00, 6'd63, 6'd5,  5'b01111};
    vec[5] = '{10'b00_00_00_00_11, 6'd63, 6'd63, 5'b00100};
    vec[6] = '{10'b00_00_00_00_10, 6'd5,  6'd63, 5'b00101};
    vec[7] = '{10'b00_00_00_00_00, 6'd0,  6'd5,  5'b01110};
    vec[8] = '{10'b00_00_00_00_00, 6'd0,  6'd6,  5'b00000};

    #2;
    set_ra(6'd5);
    #1;
    chk_reads("por", 5'b00000);
    chk_scan_idle("por");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      {dwen0, dwd0, dwen1, dwd1, vwen0, vwd0, vwen1, vwd1, lwen, lwd} = vec[i].wctl;
      dwa0 = vec[i].wa; dwa1 = vec[i].wa; vwa0 = vec[i].wa; vwa1 = vec[i].wa; lwa = vec[i].wa;
      set_ra(vec[i].ra);
      #1;
      chk_reads($sformatf("vec%0d", i), vec[i].exp);
      cyc();
    end
    {dwen0, dwd0, dwen1, dwd1, vwen0, vwd0, vwen1, vwd1, lwen, lwd} = '0;

    // async reset mid-cycle clears line 5 (d1,v0,v1 set) with no clock edge
    set_ra(6'd5);
    #1;
    chk_reads("pre_rst", 5'b01110);
    #2 rst_n = 1'b0;
    #1;
    chk_reads("async_rst", 5'b00000);
    chk_scan_idle("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // lines: (3,w1) valid+dirty, (10,w0) valid+dirty, (20,w0) dirty only
    dwen0 = 1; dwa0 = 10; dwd0 = 1; vwen0 = 1; vwa0 = 10; vwd0 = 1;
    dwen1 = 1; dwa1 = 3;  dwd1 = 1; vwen1 = 1; vwa1 = 3;  vwd1 = 1;
    cyc();
    dwen1 = 0; vwen0 = 0; vwen1 = 0; dwa0 = 20;
    cyc();
    dwen0 = 0;
    scan_ready = 1; scan_start = 1;
    cyc();
    scan_start = 0;
    emits = 0; done_at = 0;
    for (int c = 1; c <= 300 && done_at == 0; c++) begin
      if (c == 1) chk("busy_after_start", {31'd0, scan_busy}, 1);
      if (scan_valid) begin
        if (emits < 2) begin
          chk($sformatf("emit%0d_idx", emits), {26'd0, scan_idx}, ei[emits]);
          chk($sformatf("emit%0d_way", emits), {31'd0, scan_way}, ew[emits]);
        end
        emits++;
      end
      if (scan_done) done_at = c;
      else cyc();
    end
    chk("emit_count", emits, 2);
    chk("done_cycle", done_at, 131);
    cyc();
    chk("busy_after_done", {31'd0, scan_busy}, 0);
    chk("done_one_cycle", {31'd0, scan_done}, 0);
    dra1 = 3; dra0 = 10;
    #1;
    chk("cleared_d1_3", {31'd0, drd1}, 0);
    chk("cleared_d0_10", {31'd0, drd0}, 0);
    dra0 = 20;
    #1;
    chk("kept_d0_20", {31'd0, drd0}, 1);

    // backpressure on (3,w1), valid dropped mid-EMIT, external write colliding with clear
    dwen1 = 1; dwa1 = 3; dwd1 = 1;
    cyc();
    dwen1 = 0; scan_ready = 0; scan_start = 1;
    cyc();
    scan_start = 0;
    seen = 0;
    for (int c = 0; c < 200 && seen == 0; c++) begin
      if (scan_valid) seen = 1;
      else cyc();
    end
    chk("bp_emit_seen", seen, 1);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp%0d_valid", k), {31'd0, scan_valid}, 1);
      chk($sformatf("bp%0d_idx", k), {26'd0, scan_idx}, 3);
      chk($sformatf("bp%0d_way", k), {31'd0, scan_way}, 1);
      if (k == 1) begin vwen1 = 1; vwa1 = 3; vwd1 = 0; end
      cyc();
      vwen1 = 0;
    end
    chk("bp_hold_valid", {31'd0, scan_valid}, 1);
    scan_ready = 1; dwen1 = 1; dwa1 = 3; dwd1 = 1;
    cyc();
    dwen1 = 0;
    chk("bp_after_hs_valid", {31'd0, scan_valid}, 0);
    dra1 = 3;
    #1;
    chk("ext_write_wins", {31'd0, drd1}, 1);
    emits = 0; seen = 0;
    for (int c = 0; c < 200 && seen == 0; c++) begin
      if (scan_valid) emits++;
      if (scan_done) seen = 1;
      else cyc();
    end
    chk("bp_done_seen", seen, 1);
    chk("bp_no_revisit", emits, 0);
    cyc();

    // reset mid-scan at idx 30 aborts without a done pulse
    scan_start = 1;
    cyc();
    scan_start = 0;
    seen = 0;
    for (int c = 0; c < 200 && seen == 0; c++) begin
      if (scan_idx == 6'd30) seen = 1;
      else cyc();
    end
    chk("reach_idx30", seen, 1);
    chk("idx30_busy", {31'd0, scan_busy}, 1);
    #2 rst_n = 1'b0;
    #1;
    chk_scan_idle("mid_scan_rst");
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      cyc();
      if (scan_done || scan_busy) seen = 1;
    end
    chk("no_done_after_abort", seen, 0);
    scan_start = 1;
    cyc();
    scan_start = 0;
    chk("restart_busy", {31'd0, scan_busy}, 1);
    chk("restart_idx", {26'd0, scan_idx}, 0);
    chk("restart_way", {31'd0, scan_way}, 0);
    cyc();
    chk("advance_idx", {26'd0, scan_idx}, 0);
    chk("advance_way", {31'd0, scan_way}, 1);
    cyc();
    chk("advance2_idx", {26'd0, scan_idx}, 1);
    chk("advance2_way", {31'd0, scan_way}, 0);
    seen = 0;
    for (int c = 0; c < 200 && seen == 0; c++) begin
      if (scan_done) seen = 1;
      else cyc();
    end
    chk("restart_done_seen", seen, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
